controllogic: RTL and testbench
===============================

// Module: controllogic
// PURPOSE
//  Control-signal decoder for the m/n/i/temp datapath (INIT->CHECK->EXCHANGE->PRELOOP->LOOP->END flow).
//  Takes the 5-bit FSM state from the sequencer and drives RAM strobes, register enables, mux selects and ALU/flag controls.
//  Outputs are registered, giving a glitch-free, one-cycle-late copy of the decode.
// PARAMETERS
//  STATE_W  5  width of state input (fixed; codes below assume 5)
// PORTS
//  clk        in   1  single system clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  state      in   5  current sequencer state code
//  ready      out  1  block idle/done
//  ram_rd_en  out  1  RAM read strobe
//  ram_wr_en  out  1  RAM write strobe
//  EN_ALU     out  1  ALU result register enable
//  EN_DIV     out  1  divider start/enable
//  EN_m, EN_n, EN_i, EN_temp  out  1 each  register load enables
//  MX_A       out  3  ALU A: 0=m 1=n 2=i 3=temp 4=RAM data 5=const0 6=const1 7=div result
//  MX_B       out  2  ALU B: 0=const0 1=n 2=const1 3=temp
//  MX_EAB     out  2  RAM address: 0=addr m 1=addr n 2=result addr 3=i-indexed
//  MX_EDB     out  1  RAM write data: 0=ALU result 1=temp
//  SET_S1     out  1  latch ALU sign flag
//  SET_Z1     out  1  latch ALU zero flag
//  SUB1       out  1  ALU op: 1=A-B, 0=A+B
// BEHAVIOUR
//  Clocking, reset, latency
//  - reset_n=0: all outputs 0 immediately.
//  - Each rising clk: outputs <= decode(state). Latency is 1 cycle; no handshake.
//  Decode rules
//  - Any signal not listed for a state is 0 (mux selects 0).
//  - Unused code 5'b11111 decodes to all-zero.
//  Decode table
//  00 IDLE: ready
//  01 INIT1: rd, EAB=0, A=4, ALU, m
//  02 INIT2: rd, EAB=1, A=4, ALU, n
//  03 INIT3: A=5, ALU, i
//  04 INIT4: A=6, ALU, temp
//  05 CHECK1: A=0, B=1, SUB1, S1
//  06 CHECK2: A=0, Z1
//  07 CHECK3: A=1, Z1
//  08 CHECK4: A=2, B=2, SUB1, S1
//  09 CHECK5: rd, EAB=3, A=4, ALU, temp
//  0A CHECK6: A=3, Z1
//  0B CHECK7: A=3, B=1, SUB1, S1
//  0C CHECK8: none
//  0D EXCH1: A=0, ALU, temp
//  0E EXCH2: A=1, ALU, m
//  0F EXCH3: A=3, ALU, n
//  10 PRE1: A=5, ALU, i
//  11 PRE2: A=0, ALU, temp
//  12 LOOP1: A=3, B=1, DIV
//  13 LOOP2: A=7, ALU, temp
//  14 LOOP3: A=3, Z1
//  15 LOOP4: wr, EAB=3, EDB=1
//  16 LOOP5: A=2, B=2, ALU, i
//  17 LOOP6: A=0, B=1, SUB1, ALU, temp
//  18 LOOP7: A=3, S1, Z1
//  19 LOOP8: A=1, ALU, m
//  1A LOOP9: A=3, ALU, n
//  1B LOOP10: A=2, B=2, SUB1, Z1
//  1C LOOP11: none
//  1D END1: wr, EAB=2, EDB=0, A=0, ALU
//  1E END2: ready
//  Invariants
//  - ram_rd_en and ram_wr_en are never both 1.
//  - Exactly one register enable at most per state.
//  - A state change mid-cycle only affects outputs at the next edge.
// STRUCTURE
//  - Shared package: 5-bit state localparams (IDLE..END2, UNUSED1 = 5'h1F), MX_A/MX_B/MX_EAB/MX_EDB select encodings.
//  - One combinational decode (case on state) feeding a single output register bank; no sub-module needed.
// TESTING
//  - Assert reset_n=0 while state=LOOP4 -> all outputs 0 with no clock edge.
//  - Release reset, state=IDLE, 1 edge -> ready=1, everything else 0.
//  - Sweep codes 0x00..0x1E one per cycle -> each output vector matches the table 1 cycle later;
//    INIT1 gives rd=1, MX_EAB=0, MX_A=4, EN_ALU=1, EN_m=1.
//  - state=5'h1F -> all outputs 0.
//  - LOOP4 then END1 -> wr=1 with MX_EAB=3/MX_EDB=1, then MX_EAB=2/MX_EDB=0; rd stays 0.
//  - Pulse reset_n low during LOOP1 (EN_DIV=1) -> EN_DIV drops to 0 asynchronously
//    and returns to 1 on the first edge after release.

Source files
------------

// File: rtl/controllogic_pkg.sv
// Shared state codes, select encodings and the control-word layout for the
// m/n/i/temp datapath decoder.
package controllogic_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] S_IDLE    = 5'h00;
  localparam logic [STATE_W-1:0] S_INIT1   = 5'h01;
  localparam logic [STATE_W-1:0] S_INIT2   = 5'h02;
  localparam logic [STATE_W-1:0] S_INIT3   = 5'h03;
  localparam logic [STATE_W-1:0] S_INIT4   = 5'h04;
  localparam logic [STATE_W-1:0] S_CHECK1  = 5'h05;
  localparam logic [STATE_W-1:0] S_CHECK2  = 5'h06;
  localparam logic [STATE_W-1:0] S_CHECK3  = 5'h07;
  localparam logic [STATE_W-1:0] S_CHECK4  = 5'h08;
  localparam logic [STATE_W-1:0] S_CHECK5  = 5'h09;
  localparam logic [STATE_W-1:0] S_CHECK6  = 5'h0A;
  localparam logic [STATE_W-1:0] S_CHECK7  = 5'h0B;
  localparam logic [STATE_W-1:0] S_CHECK8  = 5'h0C;
  localparam logic [STATE_W-1:0] S_EXCH1   = 5'h0D;
  localparam logic [STATE_W-1:0] S_EXCH2   = 5'h0E;
  localparam logic [STATE_W-1:0] S_EXCH3   = 5'h0F;
  localparam logic [STATE_W-1:0] S_PRE1    = 5'h10;
  localparam logic [STATE_W-1:0] S_PRE2    = 5'h11;
  localparam logic [STATE_W-1:0] S_LOOP1   = 5'h12;
  localparam logic [STATE_W-1:0] S_LOOP2   = 5'h13;
  localparam logic [STATE_W-1:0] S_LOOP3   = 5'h14;
  localparam logic [STATE_W-1:0] S_LOOP4   = 5'h15;
  localparam logic [STATE_W-1:0] S_LOOP5   = 5'h16;
  localparam logic [STATE_W-1:0] S_LOOP6   = 5'h17;
  localparam logic [STATE_W-1:0] S_LOOP7   = 5'h18;
  localparam logic [STATE_W-1:0] S_LOOP8   = 5'h19;
  localparam logic [STATE_W-1:0] S_LOOP9   = 5'h1A;
  localparam logic [STATE_W-1:0] S_LOOP10  = 5'h1B;
  localparam logic [STATE_W-1:0] S_LOOP11  = 5'h1C;
  localparam logic [STATE_W-1:0] S_END1    = 5'h1D;
  localparam logic [STATE_W-1:0] S_END2    = 5'h1E;
  localparam logic [STATE_W-1:0] S_UNUSED1 = 5'h1F;

  localparam logic [2:0] MXA_M     = 3'd0;
  localparam logic [2:0] MXA_N     = 3'd1;
  localparam logic [2:0] MXA_I     = 3'd2;
  localparam logic [2:0] MXA_TEMP  = 3'd3;
  localparam logic [2:0] MXA_RAM   = 3'd4;
  localparam logic [2:0] MXA_ZERO  = 3'd5;
  localparam logic [2:0] MXA_ONE   = 3'd6;
  localparam logic [2:0] MXA_DIV   = 3'd7;

  localparam logic [1:0] MXB_ZERO  = 2'd0;
  localparam logic [1:0] MXB_N     = 2'd1;
  localparam logic [1:0] MXB_ONE   = 2'd2;
  localparam logic [1:0] MXB_TEMP  = 2'd3;

  localparam logic [1:0] EAB_M     = 2'd0;
  localparam logic [1:0] EAB_N     = 2'd1;
  localparam logic [1:0] EAB_RES   = 2'd2;
  localparam logic [1:0] EAB_IDX   = 2'd3;

  localparam logic EDB_ALU  = 1'b0;
  localparam logic EDB_TEMP = 1'b1;

  typedef struct packed {
    logic       ready;
    logic       ram_rd_en;
    logic       ram_wr_en;
    logic       en_alu;
    logic       en_div;
    logic       en_m;
    logic       en_n;
    logic       en_i;
    logic       en_temp;
    logic [2:0] mx_a;
    logic [1:0] mx_b;
    logic [1:0] mx_eab;
    logic       mx_edb;
    logic       set_s1;
    logic       set_z1;
    logic       sub1;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/controllogic_if.sv
// Sequencer-to-decoder bundle: state code in, datapath control strobes out.
interface controllogic_if;
  import controllogic_pkg::*;

  logic [STATE_W-1:0] state;
  logic               ready;
  logic               ram_rd_en;
  logic               ram_wr_en;
  logic               EN_ALU;
  logic               EN_DIV;
  logic               EN_m;
  logic               EN_n;
  logic               EN_i;
  logic               EN_temp;
  logic [2:0]         MX_A;
  logic [1:0]         MX_B;
  logic [1:0]         MX_EAB;
  logic               MX_EDB;
  logic               SET_S1;
  logic               SET_Z1;
  logic               SUB1;

  modport master (
    output state,
    input  ready, ram_rd_en, ram_wr_en, EN_ALU, EN_DIV, EN_m, EN_n, EN_i, EN_temp,
    input  MX_A, MX_B, MX_EAB, MX_EDB, SET_S1, SET_Z1, SUB1
  );

  modport slave (
    input  state,
    output ready, ram_rd_en, ram_wr_en, EN_ALU, EN_DIV, EN_m, EN_n, EN_i, EN_temp,
    output MX_A, MX_B, MX_EAB, MX_EDB, SET_S1, SET_Z1, SUB1
  );

endinterface

// File: rtl/controllogic.sv
// Control decoder: state code -> datapath strobes, registered so every output
// is a glitch-free copy of the decode one clock later.
module controllogic
  import controllogic_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  controllogic_if.slave  bus
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  always_comb begin
    ctrl_d = CTRL_NONE;
    case (bus.state)
      S_IDLE:   ctrl_d.ready = 1'b1;
      S_INIT1: begin
        ctrl_d.ram_rd_en = 1'b1; ctrl_d.mx_eab = EAB_M; ctrl_d.mx_a = MXA_RAM;
        ctrl_d.en_alu = 1'b1; ctrl_d.en_m = 1'b1;
      end
      S_INIT2: begin
        ctrl_d.ram_rd_en = 1'b1; ctrl_d.mx_eab = EAB_N; ctrl_d.mx_a = MXA_RAM;
        ctrl_d.en_alu = 1'b1; ctrl_d.en_n = 1'b1;
      end
      S_INIT3:  begin ctrl_d.mx_a = MXA_ZERO; ctrl_d.en_alu = 1'b1; ctrl_d.en_i = 1'b1; end
      S_INIT4:  begin ctrl_d.mx_a = MXA_ONE; ctrl_d.en_alu = 1'b1; ctrl_d.en_temp = 1'b1; end
      S_CHECK1: begin
        ctrl_d.mx_a = MXA_M; ctrl_d.mx_b = MXB_N; ctrl_d.sub1 = 1'b1; ctrl_d.set_s1 = 1'b1;
      end
      S_CHECK2: begin ctrl_d.mx_a = MXA_M; ctrl_d.set_z1 = 1'b1; end
      S_CHECK3: begin ctrl_d.mx_a = MXA_N; ctrl_d.set_z1 = 1'b1; end
      S_CHECK4: begin
        ctrl_d.mx_a = MXA_I; ctrl_d.mx_b = MXB_ONE; ctrl_d.sub1 = 1'b1; ctrl_d.set_s1 = 1'b1;
      end
      S_CHECK5: begin
        ctrl_d.ram_rd_en = 1'b1; ctrl_d.mx_eab = EAB_IDX; ctrl_d.mx_a = MXA_RAM;
        ctrl_d.en_alu = 1'b1; ctrl_d.en_temp = 1'b1;
      end
      S_CHECK6: begin ctrl_d.mx_a = MXA_TEMP; ctrl_d.set_z1 = 1'b1; end
      S_CHECK7: begin
        ctrl_d.mx_a = MXA_TEMP; ctrl_d.mx_b = MXB_N; ctrl_d.sub1 = 1'b1; ctrl_d.set_s1 = 1'b1;
      end
      S_EXCH1:  begin ctrl_d.mx_a = MXA_M; ctrl_d.en_alu = 1'b1; ctrl_d.en_temp = 1'b1; end
      S_EXCH2:  begin ctrl_d.mx_a = MXA_N; ctrl_d.en_alu = 1'b1; ctrl_d.en_m = 1'b1; end
      S_EXCH3:  begin ctrl_d.mx_a = MXA_TEMP; ctrl_d.en_alu = 1'b1; ctrl_d.en_n = 1'b1; end
      S_PRE1:   begin ctrl_d.mx_a = MXA_ZERO; ctrl_d.en_alu = 1'b1; ctrl_d.en_i = 1'b1; end
      S_PRE2:   begin ctrl_d.mx_a = MXA_M; ctrl_d.en_alu = 1'b1; ctrl_d.en_temp = 1'b1; end
      S_LOOP1:  begin ctrl_d.mx_a = MXA_TEMP; ctrl_d.mx_b = MXB_N; ctrl_d.en_div = 1'b1; end
      S_LOOP2:  begin ctrl_d.mx_a = MXA_DIV; ctrl_d.en_alu = 1'b1; ctrl_d.en_temp = 1'b1; end
      S_LOOP3:  begin ctrl_d.mx_a = MXA_TEMP; ctrl_d.set_z1 = 1'b1; end
      S_LOOP4:  begin
        ctrl_d.ram_wr_en = 1'b1; ctrl_d.mx_eab = EAB_IDX; ctrl_d.mx_edb = EDB_TEMP;
      end
      S_LOOP5:  begin
        ctrl_d.mx_a = MXA_I; ctrl_d.mx_b = MXB_ONE; ctrl_d.en_alu = 1'b1; ctrl_d.en_i = 1'b1;
      end
      S_LOOP6:  begin
        ctrl_d.mx_a = MXA_M; ctrl_d.mx_b = MXB_N; ctrl_d.sub1 = 1'b1;
        ctrl_d.en_alu = 1'b1; ctrl_d.en_temp = 1'b1;
      end
      S_LOOP7:  begin ctrl_d.mx_a = MXA_TEMP; ctrl_d.set_s1 = 1'b1; ctrl_d.set_z1 = 1'b1; end
      S_LOOP8:  begin ctrl_d.mx_a = MXA_N; ctrl_d.en_alu = 1'b1; ctrl_d.en_m = 1'b1; end
      S_LOOP9:  begin ctrl_d.mx_a = MXA_TEMP; ctrl_d.en_alu = 1'b1; ctrl_d.en_n = 1'b1; end
      S_LOOP10: begin
        ctrl_d.mx_a = MXA_I; ctrl_d.mx_b = MXB_ONE; ctrl_d.sub1 = 1'b1; ctrl_d.set_z1 = 1'b1;
      end
      S_END1:   begin
        ctrl_d.ram_wr_en = 1'b1; ctrl_d.mx_eab = EAB_RES; ctrl_d.mx_edb = EDB_ALU;
        ctrl_d.mx_a = MXA_M; ctrl_d.en_alu = 1'b1;
      end
      S_END2:   ctrl_d.ready = 1'b1;
      // CHECK8, LOOP11 and the unused code all decode to the idle-safe word
      default:  ctrl_d = CTRL_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ctrl_q <= CTRL_NONE;
    else          ctrl_q <= ctrl_d;
  end

  assign bus.ready     = ctrl_q.ready;
  assign bus.ram_rd_en = ctrl_q.ram_rd_en;
  assign bus.ram_wr_en = ctrl_q.ram_wr_en;
  assign bus.EN_ALU    = ctrl_q.en_alu;
  assign bus.EN_DIV    = ctrl_q.en_div;
  assign bus.EN_m      = ctrl_q.en_m;
  assign bus.EN_n      = ctrl_q.en_n;
  assign bus.EN_i      = ctrl_q.en_i;
  assign bus.EN_temp   = ctrl_q.en_temp;
  assign bus.MX_A      = ctrl_q.mx_a;
  assign bus.MX_B      = ctrl_q.mx_b;
  assign bus.MX_EAB    = ctrl_q.mx_eab;
  assign bus.MX_EDB    = ctrl_q.mx_edb;
  assign bus.SET_S1    = ctrl_q.set_s1;
  assign bus.SET_Z1    = ctrl_q.set_z1;
  assign bus.SUB1      = ctrl_q.sub1;

endmodule

// File: tb/tb_controllogic.sv
// Scoreboard bench for controllogic: signal-centric reference table, randomized
// state stream, plus directed async-reset and mid-cycle checks.
module tb_controllogic;

  logic clk;
  logic reset_n;

  controllogic_if bus ();

  controllogic dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference: for each output, the set of state codes that raise it.
  int ready_set[$] = '{0, 30};
  int rd_set[$]    = '{1, 2, 9};
  int wr_set[$]    = '{21, 29};
  int alu_set[$]   = '{1, 2, 3, 4, 9, 13, 14, 15, 16, 17, 19, 22, 23, 25, 26, 29};
  int div_set[$]   = '{18};
  int m_set[$]     = '{1, 14, 25};
  int n_set[$]     = '{2, 15, 26};
  int i_set[$]     = '{3, 16, 22};
  int temp_set[$]  = '{4, 9, 13, 17, 19, 23};
  int s1_set[$]    = '{5, 8, 11, 24};
  int z1_set[$]    = '{6, 7, 10, 20, 24, 27};
  int sub_set[$]   = '{5, 8, 11, 23, 27};
  int a_sel[32];
  int b_sel[32];
  int eab_sel[32];
  int edb_sel[32];

  function automatic bit has(input int s[$], input int c);
    foreach (s[k]) if (s[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_model();
    for (int c = 0; c < 32; c++) begin
      a_sel[c] = 0; b_sel[c] = 0; eab_sel[c] = 0; edb_sel[c] = 0;
    end
    a_sel[1] = 4;  a_sel[2] = 4;  a_sel[3] = 5;  a_sel[4] = 6;  a_sel[7] = 1;
    a_sel[8] = 2;  a_sel[9] = 4;  a_sel[10] = 3; a_sel[11] = 3; a_sel[14] = 1;
    a_sel[15] = 3; a_sel[16] = 5; a_sel[18] = 3; a_sel[19] = 7; a_sel[20] = 3;
    a_sel[22] = 2; a_sel[24] = 3; a_sel[25] = 1; a_sel[26] = 3; a_sel[27] = 2;
    b_sel[5] = 1;  b_sel[8] = 2;  b_sel[11] = 1; b_sel[18] = 1; b_sel[22] = 2;
    b_sel[23] = 1; b_sel[27] = 2;
    eab_sel[2] = 1; eab_sel[9] = 3; eab_sel[21] = 3; eab_sel[29] = 2;
    edb_sel[21] = 1;
  endtask

  // {ready,rd,wr,alu,div,m,n,i,temp,A[3],B[2],EAB[2],EDB,S1,Z1,SUB}
  function automatic logic [19:0] expect_vec(input int c);
    logic [2:0] a;
    logic [1:0] b;
    logic [1:0] e;
    a = 3'(a_sel[c]);
    b = 2'(b_sel[c]);
    e = 2'(eab_sel[c]);
    return {has(ready_set, c), has(rd_set, c), has(wr_set, c), has(alu_set, c),
            has(div_set, c), has(m_set, c), has(n_set, c), has(i_set, c),
            has(temp_set, c), a, b, e, edb_sel[c] != 0,
            has(s1_set, c), has(z1_set, c), has(sub_set, c)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.ready, bus.ram_rd_en, bus.ram_wr_en, bus.EN_ALU, bus.EN_DIV,
            bus.EN_m, bus.EN_n, bus.EN_i, bus.EN_temp, bus.MX_A, bus.MX_B,
            bus.MX_EAB, bus.MX_EDB, bus.SET_S1, bus.SET_Z1, bus.SUB1};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%05h expected=%05h", name, act, exp);
    end
  endtask

  typedef struct {
    int          code;
    logic [19:0] vec;
  } sb_item_t;

  sb_item_t sb_q[$];
  bit       sb_en = 1'b0;

  task automatic issue(input int c);
    sb_item_t it;
    @(negedge clk);
    bus.state = 5'(c);
    it.code = c;
    it.vec  = expect_vec(c);
    sb_q.push_back(it);
  endtask

  // Monitor: outputs reflect the state presented before the previous edge.
  always @(posedge clk) begin
    #1;
    if (sb_en && sb_q.size() > 0) begin
      sb_item_t it;
      logic [19:0] v;
      it = sb_q.pop_front();
      v  = dut_vec();
      check($sformatf("decode_%02h", it.code), v, it.vec);
      check("rd_wr_excl", 20'(bus.ram_rd_en & bus.ram_wr_en), 20'd0);
      check("one_reg_en", 20'($countones({bus.EN_m, bus.EN_n, bus.EN_i, bus.EN_temp}) > 1), 20'd0);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("sb_drain", 20'(sb_q.size()), 20'd0);
    sb_q.delete();
  endtask

  initial begin
    build_model();
    reset_n   = 1'b0;
    bus.state = 5'h15;
    #2;
    check("reset_no_edge", dut_vec(), 20'd0);
    @(posedge clk); #1;
    check("reset_held", dut_vec(), 20'd0);

    @(negedge clk);
    reset_n = 1'b1;
    sb_en   = 1'b1;
    issue(0);
    for (int c = 1; c < 32; c++) issue(c);
    issue(21);
    issue(29);
    issue(31);
    for (int k = 0; k < 300; k++) issue(int'($urandom_range(0, 31)));
    drain();
    sb_en = 1'b0;

    // A state change between edges must not reach the outputs early.
    @(negedge clk);
    bus.state = 5'h01;
    @(posedge clk); #1;
    check("init1_vec", dut_vec(), expect_vec(1));
    #2 bus.state = 5'h15;
    #1;
    check("midcycle_hold", dut_vec(), expect_vec(1));
    @(posedge clk); #1;
    check("loop4_after_edge", dut_vec(), expect_vec(21));

    // Async reset pulse during LOOP1.
    @(negedge clk);
    bus.state = 5'h12;
    @(posedge clk); #1;
    check("loop1_div", 20'(bus.EN_DIV), 20'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_clear", dut_vec(), 20'd0);
    @(posedge clk); #1;
    check("clear_held", dut_vec(), 20'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_no_edge", dut_vec(), 20'd0);
    @(posedge clk); #1;
    check("div_after_release", 20'(bus.EN_DIV), 20'd1);
    check("loop1_after_release", dut_vec(), expect_vec(18));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
